histogram_engine: RTL
=====================

Name: histogram_engine

Overview:
- Parametrised, self-sequenced histogram builder.
- On start it zero-fills the scratch bin memory, then fetches input words and splits each into pixels. For every pixel it does a pipelined read-modify-write increment of that pixel's bin counter.
- Throughput is one pixel per cycle. Forwarding covers back-to-back same-word hazards, counters saturate, and an overflow flag is sticky.
- Sits between the input pixel memory and the scratch bin memory. Completion is reported to the top-level controller.

Parameters:
- PIX_W, 8, bits per pixel.
- IN_W, 128, input memory word width; PIX_PER_WORD = IN_W/PIX_W (integer).
- NUM_BINS, 256, histogram bins; power of 2, <= 2^PIX_W.
- CNT_W, 32, bits per bin counter.
- BINS_PER_WORD, 4, counters per scratch word; power of 2. SCR_W = CNT_W*BINS_PER_WORD; DEPTH = NUM_BINS/BINS_PER_WORD.
- ADDR_W, 16, address width of both memories.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  begin job; sampled only in IDLE.
- in_base_addr  input  ADDR_W  first input word address; latched on start.
- num_words  input  ADDR_W  input words to process; latched on start.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle completion pulse.
- overflow  output  1  sticky; some counter hit saturation this job.
- in_mem_addr  output  ADDR_W  input memory read address.
- in_mem_rdata  input  IN_W  input read data, valid 1 cycle after address.
- scr_raddr  output  ADDR_W  scratch read address.
- scr_rdata  input  SCR_W  scratch read data, valid 1 cycle after address; read-during-write returns old data.
- scr_we  output  1  scratch write enable.
- scr_waddr  output  ADDR_W  scratch write address.
- scr_wdata  output  SCR_W  scratch write data.

Behaviour:
- Reset (reset==0 at a clock edge), regardless of state:
  - FSM goes to IDLE.
  - busy, done, overflow and scr_we are 0; all address and data outputs are 0.
  - Pipeline and forwarding valids are cleared.
  - Scratch contents are undefined afterwards; every job clears them itself.
- Pixel k of a word = in_mem_rdata[PIX_W*k +: PIX_W], issued k=0 first.
- bin = pixel >> (PIX_W - log2(NUM_BINS)); word = bin >> log2(BINS_PER_WORD); lane = bin mod BINS_PER_WORD.
- Lane l occupies bits [CNT_W*l +: CNT_W]; lane 0 is at the LSB.
- FSM states:
  - IDLE: start -> CLEAR; latch base and num_words; clear overflow.
  - CLEAR: one write per cycle, scr_we=1, scr_wdata=0, scr_waddr 0..DEPTH-1 (DEPTH cycles). Then FETCH if num_words!=0, else DRAIN.
  - FETCH: in_mem_addr = base + word index (wraps modulo 2^ADDR_W); 1 cycle -> LOAD.
  - LOAD: latch in_mem_rdata into the pixel register; 1 cycle -> PROC.
  - PROC: issue one pixel per cycle (PIX_PER_WORD cycles); scr_raddr = word of the current pixel. After the last pixel: FETCH if words remain, else DRAIN.
  - DRAIN: 2 cycles so in-flight writes retire; next state DONE.
  - DONE: done=1 for 1 cycle; busy=0 in this cycle -> IDLE.
- Pipeline:
  - S0 (cycle t): read issued.
  - S1 (t+1): select the base word, increment the lane, register the result.
  - S2 (t+2): scr_we=1 with that word and its address.
- Base word selection in S1:
  - Use the S2 write data if its address matches (distance-1 hazard).
  - Else use the write data registered one cycle earlier if its address matches (distance-2 hazard, write landing same edge as the read).
  - Else use scr_rdata.
  - Priority: newest match wins.
- Increment arithmetic:
  - Increment is CNT_W-bit and saturating. A lane already at all-ones stays all-ones and sets overflow.
  - Other lanes pass through unchanged.
- Pipeline state persists across the FETCH/LOAD bubbles; forwarding stays valid across input-word boundaries.
- No scr_we outside CLEAR and S2 retirements; writes never overlap CLEAR.
- start while busy is ignored.
- Latency with defaults (num_words=N): 64 CLEAR + N*18 + 2 DRAIN, then done in the next cycle.

Test Plan:
- Reset held low 2 cycles, with start also pulsed during reset -> busy=0, done=0, scr_we=0, overflow=0, all addresses 0, FSM in IDLE.
- start, num_words=0 -> 64 writes of 0 to addresses 0..63 on consecutive cycles; no in_mem_addr change; done pulse 3 cycles after the last clear write.
- One word, all 16 pixels 0x05 -> writes to address 1 with lane 1 = 1,2,...,16 on consecutive cycles (distance-1 forwarding); final scratch word 1 = 0x...0010_00000000.
- One word, pixels 0x10,0x20,0x11 repeated -> writes to word 4 never lose an increment (distance-2 forwarding); final word 4 lanes 0/1 and word 8 lane 0 match a model.
- 4 random words, in_base_addr=0xFFFE -> in_mem_addr sequence 0xFFFE,0xFFFF,0x0000,0x0001; final scratch memory equals the reference-model histogram; total count = 64.
- CNT_W=4, 2 words of 0x00 -> bin 0 counter = 15, overflow=1. Then start again: overflow clears.
- Reset mid-PROC, then a new start -> correct histogram and no stale writes.

Source files
------------

// File: rtl/histogram_engine.sv
`default_nettype none
// ============================================================================
// Module   : histogram_engine
// Brief    : Clears the scratch bin memory, then streams input words pixel by
//            pixel through a 3-stage read-modify-write increment pipeline.
// Revision : 1.0
// ============================================================================
module histogram_engine #(
    parameter int PIX_W         = 8,
    parameter int IN_W          = 128,
    parameter int NUM_BINS      = 256,
    parameter int CNT_W         = 32,
    parameter int BINS_PER_WORD = 4,
    parameter int ADDR_W        = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [ADDR_W-1:0]                in_base_addr,
    input  logic [ADDR_W-1:0]                num_words,
    output logic                             busy,
    output logic                             done,
    output logic                             overflow,
    output logic [ADDR_W-1:0]                in_mem_addr,
    input  logic [IN_W-1:0]                  in_mem_rdata,
    output logic [ADDR_W-1:0]                scr_raddr,
    input  logic [CNT_W*BINS_PER_WORD-1:0]   scr_rdata,
    output logic                             scr_we,
    output logic [ADDR_W-1:0]                scr_waddr,
    output logic [CNT_W*BINS_PER_WORD-1:0]   scr_wdata
);

    localparam int c_SCR_W        = CNT_W * BINS_PER_WORD;
    localparam int c_PIX_PER_WORD = IN_W / PIX_W;
    localparam int c_DEPTH        = NUM_BINS / BINS_PER_WORD;
    localparam int c_BIN_SHIFT    = PIX_W - $clog2(NUM_BINS);
    localparam int c_LOG_BPW      = $clog2(BINS_PER_WORD);
    localparam int c_LANE_W       = (c_LOG_BPW > 0) ? c_LOG_BPW : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_PROC  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    function automatic logic [ADDR_W-1:0] word_of(input logic [PIX_W-1:0] pix);
        logic [PIX_W-1:0] bin;
        bin = pix >> c_BIN_SHIFT;
        return ADDR_W'(bin >> c_LOG_BPW);
    endfunction

    function automatic logic [c_LANE_W-1:0] lane_of(input logic [PIX_W-1:0] pix);
        logic [PIX_W-1:0] bin;
        bin = pix >> c_BIN_SHIFT;
        return (c_LOG_BPW > 0) ? c_LANE_W'(bin) : '0;
    endfunction

    logic [2:0]          r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_num;
    logic [ADDR_W-1:0]   r_widx;
    logic [IN_W-1:0]     r_pix;
    logic                r_busy;
    logic                r_done;
    logic                r_overflow;
    logic [ADDR_W-1:0]   r_in_addr;
    logic                r_s0_valid;
    logic [c_LANE_W-1:0] r_s0_lane;
    logic [ADDR_W-1:0]   r_scr_raddr;
    logic                r_s1_valid;
    logic [ADDR_W-1:0]   r_s1_addr;
    logic [c_LANE_W-1:0] r_s1_lane;
    logic                r_scr_we;
    logic [ADDR_W-1:0]   r_scr_waddr;
    logic [c_SCR_W-1:0]  r_scr_wdata;
    logic                r_fwd_we;
    logic [ADDR_W-1:0]   r_fwd_addr;
    logic [c_SCR_W-1:0]  r_fwd_data;

    logic [c_SCR_W-1:0]  w_base;
    logic [c_SCR_W-1:0]  w_new;
    logic                w_sat;

    // Newest matching write wins: the word in S2 beats the one written last edge.
    always_comb begin
        w_base = scr_rdata;
        if (r_fwd_we && (r_fwd_addr == r_s1_addr)) w_base = r_fwd_data;
        if (r_scr_we && (r_scr_waddr == r_s1_addr)) w_base = r_scr_wdata;
        w_new = w_base;
        w_sat = 1'b0;
        for (int l = 0; l < BINS_PER_WORD; l++) begin
            if (c_LANE_W'(l) == r_s1_lane) begin
                if (&w_base[CNT_W*l +: CNT_W]) w_sat = 1'b1;
                else w_new[CNT_W*l +: CNT_W] = w_base[CNT_W*l +: CNT_W] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_base      <= '0;
            r_num       <= '0;
            r_widx      <= '0;
            r_pix       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_in_addr   <= '0;
            r_s0_valid  <= 1'b0;
            r_s0_lane   <= '0;
            r_scr_raddr <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_addr   <= '0;
            r_s1_lane   <= '0;
            r_scr_we    <= 1'b0;
            r_scr_waddr <= '0;
            r_scr_wdata <= '0;
            r_fwd_we    <= 1'b0;
            r_fwd_addr  <= '0;
            r_fwd_data  <= '0;
        end else begin
            // The increment pipeline advances every cycle independent of the FSM.
            r_s1_valid <= r_s0_valid;
            r_s1_addr  <= r_scr_raddr;
            r_s1_lane  <= r_s0_lane;
            r_scr_we   <= r_s1_valid;
            if (r_s1_valid) begin
                r_scr_waddr <= r_s1_addr;
                r_scr_wdata <= w_new;
                if (w_sat) r_overflow <= 1'b1;
            end
            r_fwd_we   <= r_scr_we;
            r_fwd_addr <= r_scr_waddr;
            r_fwd_data <= r_scr_wdata;
            r_done     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_CLEAR;
                        r_busy      <= 1'b1;
                        r_base      <= in_base_addr;
                        r_num       <= num_words;
                        r_overflow  <= 1'b0;
                        r_cnt       <= '0;
                        r_scr_we    <= 1'b1;
                        r_scr_waddr <= '0;
                        r_scr_wdata <= '0;
                    end
                end
                S_CLEAR: begin
                    r_scr_wdata <= '0;
                    if (r_cnt == ADDR_W'(c_DEPTH - 1)) begin
                        r_scr_we <= 1'b0;
                        r_cnt    <= '0;
                        if (r_num != '0) begin
                            r_state   <= S_FETCH;
                            r_in_addr <= r_base;
                            r_widx    <= '0;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else begin
                        r_scr_we    <= 1'b1;
                        r_scr_waddr <= r_cnt + ADDR_W'(1);
                        r_cnt       <= r_cnt + ADDR_W'(1);
                    end
                end
                S_FETCH: r_state <= S_LOAD;
                S_LOAD: begin
                    r_state     <= S_PROC;
                    r_pix       <= in_mem_rdata >> PIX_W;
                    r_s0_valid  <= 1'b1;
                    r_s0_lane   <= lane_of(in_mem_rdata[PIX_W-1:0]);
                    r_scr_raddr <= word_of(in_mem_rdata[PIX_W-1:0]);
                    r_cnt       <= '0;
                end
                S_PROC: begin
                    if (r_cnt == ADDR_W'(c_PIX_PER_WORD - 1)) begin
                        r_s0_valid <= 1'b0;
                        r_cnt      <= '0;
                        if (r_widx + ADDR_W'(1) == r_num) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state   <= S_FETCH;
                            r_widx    <= r_widx + ADDR_W'(1);
                            r_in_addr <= r_in_addr + ADDR_W'(1);
                        end
                    end else begin
                        r_pix       <= r_pix >> PIX_W;
                        r_s0_lane   <= lane_of(r_pix[PIX_W-1:0]);
                        r_scr_raddr <= word_of(r_pix[PIX_W-1:0]);
                        r_cnt       <= r_cnt + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == ADDR_W'(1)) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign overflow    = r_overflow;
    assign in_mem_addr = r_in_addr;
    assign scr_raddr   = r_scr_raddr;
    assign scr_we      = r_scr_we;
    assign scr_waddr   = r_scr_waddr;
    assign scr_wdata   = r_scr_wdata;

endmodule
`default_nettype wire
